// File: rtl/pulse_emitter.sv
// pulse_emitter: turns single-cycle request strobes into fixed-width high
// levels on line_out, each followed by a guaranteed low gap, so a downstream
// pulse tracer sees exactly one clean pulse per request. Requests that arrive
// while a pulse is in flight are queued in a saturating counter; a request
// that finds the queue full is dropped and flagged in a sticky overflow bit.
module pulse_emitter #(
  parameter int HOLD_LEN = 4,
  parameter int GAP_LEN  = 3,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              line_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              tx_done
);

  localparam int MAXL = (HOLD_LEN > GAP_LEN) ? HOLD_LEN : GAP_LEN;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0]     HOLD_LD  = CW'(HOLD_LEN - 1);
  localparam logic [CW-1:0]     GAP_LD   = CW'(GAP_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic last_gap;
  logic queue_req;
  logic drop;

  // Last GAP edge: sequence completes and the next pulse may start here.
  // At every other busy edge a strobe goes to the queue instead.
  assign last_gap  = (state == GAP) && (cnt == '0);
  assign queue_req = pulse_in && ((state == HIGH) || ((state == GAP) && (cnt != '0)));
  assign drop      = queue_req && (pending == PEND_MAX);

  // busy is a decode of the state register only, never of inputs.
  assign busy = (state != IDLE);

  // Phase sequencer: IDLE -> HIGH (HOLD_LEN) -> GAP (GAP_LEN) -> next/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      line_out <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state    <= HIGH;
            line_out <= 1'b1;
            cnt      <= HOLD_LD;
          end
        end
        HIGH: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state    <= GAP;
            line_out <= 1'b0;
            cnt      <= GAP_LD;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            tx_done <= 1'b1;
            if ((pending != '0) || pulse_in) begin
              state    <= HIGH;
              line_out <= 1'b1;
              cnt      <= HOLD_LD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          line_out <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

  // Pending queue: saturating increment while busy; at the last GAP edge one
  // queued request is consumed, and a simultaneous strobe replaces it, so the
  // net count never grows there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (last_gap) begin
      if ((pending != '0) && !pulse_in) pending <= pending - 1'b1;
    end else if (queue_req && !drop) begin
      pending <= pending + 1'b1;
    end
  end

  // Sticky overflow; a drop on the same edge as clr_ovf keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_pulse_emitter.sv
// Directed bench for pulse_emitter (HOLD_LEN=4, GAP_LEN=3, PEND_W=2).
// Waveforms are given as bit masks indexed by edge number, where bit e is the
// value observed just after edge e; strobe bit e is driven before edge e.
module tb_pulse_emitter;

  localparam int HOLD_LEN   = 4;
  localparam int GAP_LEN    = 3;
  localparam int PEND_W     = 2;
  localparam int FILTER_LEN = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pulse_in;
  logic              clr_ovf;
  logic              line_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              tx_done;

  int ncmp  = 0;
  int nfail = 0;
  logic [PEND_W-1:0] pend_log [64];

  // Receiver model: a pulse registers once the line has been high for
  // FILTER_LEN consecutive samples; one pulse per high run.
  logic trc_en = 1'b0;
  int   trc_run = 0;
  int   trc_pulses = 0;
  int   rises = 0;
  logic line_q = 1'b0;

  pulse_emitter #(.HOLD_LEN(HOLD_LEN), .GAP_LEN(GAP_LEN), .PEND_W(PEND_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .clr_ovf  (clr_ovf),
    .line_out (line_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    line_q <= line_out;
    if (trc_en) begin
      if (line_out && !line_q) rises <= rises + 1;
      if (!line_out) trc_run <= 0;
      else if (trc_run < FILTER_LEN) begin
        trc_run <= trc_run + 1;
        if (trc_run + 1 == FILTER_LEN) trc_pulses <= trc_pulses + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic c);
    pulse_in = p;
    clr_ovf  = c;
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic wave(input string tag, input int n, input logic [63:0] strb,
                      input logic [63:0] line_m, input logic [63:0] busy_m,
                      input logic [63:0] done_m);
    for (int e = 0; e < n; e++) begin
      cyc(strb[e], 1'b0);
      pend_log[e] = pending;
      chk($sformatf("%s line e%0d", tag, e), {31'b0, line_out}, {31'b0, line_m[e]});
      chk($sformatf("%s busy e%0d", tag, e), {31'b0, busy},     {31'b0, busy_m[e]});
      chk($sformatf("%s done e%0d", tag, e), {31'b0, tx_done},  {31'b0, done_m[e]});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst line",    {31'b0, line_out}, 32'd0);
    chk("rst busy",    {31'b0, busy},     32'd0);
    chk("rst pending", {30'b0, pending},  32'd0);
    chk("rst ovf",     {31'b0, overflow}, 32'd0);
    chk("rst done",    {31'b0, tx_done},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0);

    // 1: single strobe
    wave("t1", 10, 64'h1, 64'hF, 64'h7F, 64'h80);
    for (int e = 0; e < 10; e++) chk($sformatf("t1 pend e%0d", e), {30'b0, pend_log[e]}, 32'd0);

    // 2: three consecutive strobes, three pulses at period 7
    wave("t2", 24, 64'h7, 64'h3C78F, 64'h1FFFFF, 64'h204080);
    chk("t2 pend e1",  {30'b0, pend_log[1]},  32'd1);
    chk("t2 pend e2",  {30'b0, pend_log[2]},  32'd2);
    chk("t2 pend e6",  {30'b0, pend_log[6]},  32'd2);
    chk("t2 pend e7",  {30'b0, pend_log[7]},  32'd1);
    chk("t2 pend e14", {30'b0, pend_log[14]}, 32'd0);
    chk("t2 ovf",      {31'b0, overflow},     32'd0);

    // 3: five strobes, queue saturates, fifth dropped, four pulses
    wave("t3", 31, 64'h1F, 64'h1E3C78F, 64'hFFFFFFF, 64'h10204080);
    chk("t3 pend e3",  {30'b0, pend_log[3]},  32'd3);
    chk("t3 pend e4",  {30'b0, pend_log[4]},  32'd3);
    chk("t3 pend e7",  {30'b0, pend_log[7]},  32'd2);
    chk("t3 pend e14", {30'b0, pend_log[14]}, 32'd1);
    chk("t3 pend e21", {30'b0, pend_log[21]}, 32'd0);
    chk("t3 ovf set",  {31'b0, overflow},     32'd1);
    cyc(0, 1);
    chk("t3 ovf clr",  {31'b0, overflow},     32'd0);

    // 4: strobe exactly on the last GAP edge chains with no idle cycle
    wave("t4", 17, 64'h81, 64'h78F, 64'h3FFF, 64'h4080);
    chk("t4 pend e7", {30'b0, pend_log[7]}, 32'd0);
    chk("t4 pend e8", {30'b0, pend_log[8]}, 32'd0);
    chk("t4 ovf",     {31'b0, overflow},    32'd0);

    // 5: asynchronous reset in the middle of a high phase
    repeat (5) cyc(1, 0);
    repeat (4) cyc(0, 0);
    chk("t5 pre line", {31'b0, line_out}, 32'd1);
    chk("t5 pre pend", {30'b0, pending},  32'd2);
    chk("t5 pre ovf",  {31'b0, overflow}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 rst line", {31'b0, line_out}, 32'd0);
    chk("t5 rst busy", {31'b0, busy},     32'd0);
    chk("t5 rst pend", {30'b0, pending},  32'd0);
    chk("t5 rst ovf",  {31'b0, overflow}, 32'd0);
    chk("t5 rst done", {31'b0, tx_done},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wave("t5", 9, 64'h1, 64'hF, 64'h7F, 64'h80);

    // 6: loopback into receiver model, 10 strobes with random spacing
    trc_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      repeat ($urandom_range(6, 14)) cyc(0, 0);
    end
    for (int i = 0; i < 40 && busy; i++) cyc(0, 0);
    cyc(0, 0);
    chk("t6 idle",     {31'b0, busy},     32'd0);
    chk("t6 ovf",      {31'b0, overflow}, 32'd0);
    chk("t6 rises",    rises,             32'd10);
    chk("t6 tracer",   trc_pulses,        32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
